// File: rtl/bcd_sel_encoder.sv
// bcd_sel_encoder: keypad digit accumulator that maps a 1..4 digit BCD entry
// onto the 3-bit current (selC) or frequency (selF) select code.
// Optional feature macro: BCD_SEL_NEAREST_MATCH_EN -- when defined, a value
// with no exact table entry rounds down to the largest entry below it and is
// flagged with approx; when undefined every non-exact value is an error.
module bcd_sel_encoder #(
   parameter int unsigned MAX_DIGITS  = 4,
   parameter int unsigned TIMEOUT_CYC = 0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       mode,
   input  logic [3:0] digit_in,
   input  logic       digit_valid,
   input  logic       enter,
   input  logic       clear,
   output logic [2:0] selC,
   output logic [2:0] selF,
   output logic       sel_valid,
   output logic       err,
   output logic       approx,
   output logic       busy,
   output logic [2:0] digit_cnt,
   output logic [3:0] r0,
   output logic [3:0] r1,
   output logic [3:0] r2,
   output logic [3:0] r3
);

   // 14 bits hold the largest 4-digit entry (9999)
   localparam int unsigned VW      = 14;
   localparam int unsigned TW      = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [TW-1:0] T_LAST = TW'((TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1);
   localparam logic [2:0]  MAX_CNT = 3'(MAX_DIGITS);

   typedef enum logic [1:0] {IDLE, ENTRY, MATCH, DONE} state_t;

   state_t          state;
   logic            mode_q;
   logic [TW-1:0]   tcnt;
   logic            res_ok;
   logic            res_approx;
   logic [2:0]      res_code;

   logic [VW-1:0]   value_c;
   logic            hit_c;
   logic [2:0]      hit_code_c;
   logic            near_c;
   logic [2:0]      near_code_c;

   // Table lookup: code -> value for the current or frequency table
   function automatic logic [VW-1:0] tab_val(input logic freq, input logic [2:0] code);
      logic [VW-1:0] v;
      v = '0;
      if (freq) begin
         case (code)
            3'd0: v = VW'(30);
            3'd1: v = VW'(50);
            3'd2: v = VW'(75);
            3'd3: v = VW'(100);
            3'd4: v = VW'(125);
            3'd5: v = VW'(150);
            3'd6: v = VW'(175);
            3'd7: v = VW'(200);
         endcase
      end else begin
         case (code)
            3'd0: v = VW'(10);
            3'd1: v = VW'(50);
            3'd2: v = VW'(100);
            3'd3: v = VW'(200);
            3'd4: v = VW'(400);
            3'd5: v = VW'(600);
            3'd6: v = VW'(800);
            3'd7: v = VW'(1000);
         endcase
      end
      return v;
   endfunction

   // Binary value of the BCD entry; leading zeros fall out naturally
   assign value_c = VW'(r3) * VW'(1000) + VW'(r2) * VW'(100)
                  + VW'(r1) * VW'(10) + VW'(r0);

   // Search the latched table for an exact hit and the nearest entry below
   always_comb begin
      hit_c       = 1'b0;
      hit_code_c  = '0;
      near_c      = 1'b0;
      near_code_c = '0;
      for (int i = 0; i < 8; i++) begin
         if (tab_val(mode_q, 3'(i)) == value_c) begin
            hit_c      = 1'b1;
            hit_code_c = 3'(i);
         end
`ifdef BCD_SEL_NEAREST_MATCH_EN
         // Tables are ascending, so the last entry below the value wins
         if (tab_val(mode_q, 3'(i)) < value_c) begin
            near_c      = 1'b1;
            near_code_c = 3'(i);
         end
`endif
      end
   end

   // Entry FSM: digit collection, match, commit and timeout
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         mode_q     <= 1'b0;
         tcnt       <= '0;
         res_ok     <= 1'b0;
         res_approx <= 1'b0;
         res_code   <= '0;
         selC       <= '0;
         selF       <= '0;
         sel_valid  <= 1'b0;
         err        <= 1'b0;
         approx     <= 1'b0;
         busy       <= 1'b0;
         digit_cnt  <= '0;
         r0         <= '0;
         r1         <= '0;
         r2         <= '0;
         r3         <= '0;
      end else begin
         sel_valid <= 1'b0;
         err       <= 1'b0;
         approx    <= 1'b0;
         case (state)
            IDLE, ENTRY: begin
               if (clear) begin
                  r0        <= '0;
                  r1        <= '0;
                  r2        <= '0;
                  r3        <= '0;
                  digit_cnt <= '0;
                  tcnt      <= '0;
                  state     <= IDLE;
               end else if (enter) begin
                  if (digit_cnt == 3'd0) begin
                     err <= 1'b1;
                  end else begin
                     mode_q <= mode;
                     busy   <= 1'b1;
                     state  <= MATCH;
                  end
               end else if (digit_valid) begin
                  if (digit_in <= 4'd9 && digit_cnt < MAX_CNT) begin
                     r3        <= r2;
                     r2        <= r1;
                     r1        <= r0;
                     r0        <= digit_in;
                     digit_cnt <= digit_cnt + 3'd1;
                     tcnt      <= '0;
                     state     <= ENTRY;
                  end else begin
                     err <= 1'b1;
                  end
               end else if (TIMEOUT_CYC != 0 && state == ENTRY) begin
                  if (tcnt == T_LAST) begin
                     r0        <= '0;
                     r1        <= '0;
                     r2        <= '0;
                     r3        <= '0;
                     digit_cnt <= '0;
                     tcnt      <= '0;
                     err       <= 1'b1;
                     state     <= IDLE;
                  end else begin
                     tcnt <= tcnt + TW'(1);
                  end
               end
            end
            MATCH: begin
               res_ok     <= hit_c | near_c;
               res_approx <= ~hit_c & near_c;
               res_code   <= hit_c ? hit_code_c : near_code_c;
               state      <= DONE;
            end
            DONE: begin
               if (res_ok) begin
                  if (mode_q) selF <= res_code;
                  else        selC <= res_code;
                  sel_valid <= 1'b1;
                  approx    <= res_approx;
               end else begin
                  err <= 1'b1;
               end
               r0        <= '0;
               r1        <= '0;
               r2        <= '0;
               r3        <= '0;
               digit_cnt <= '0;
               tcnt      <= '0;
               busy      <= 1'b0;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
